// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: widths, op encodings,
// FSM states and the magnitude helper used for signed operands.
package mdu_pkg;

  localparam int WIDTH      = 32;
  localparam int ITER_COUNT = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MUL   = 3'd1,
    S_DIV   = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // 32'h80000000 maps onto itself, which is the correct unsigned magnitude 2^31.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// remainder, subtract the divisor when it fits, and shift the quotient bit in.
module mdu_div_step
  import mdu_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);

  logic [W:0] shifted;
  logic [W:0] diff;
  logic       ge;

  always_comb begin
    shifted = {rem_i, quo_i[W-1]};
    diff    = shifted - {1'b0, divisor_i};
    ge      = shifted >= {1'b0, divisor_i};
    rem_o   = ge ? diff[W-1:0] : shifted[W-1:0];
    quo_o   = {quo_i[W-2:0], ge};
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers; 34-edge latency.
// Divider is built only when MDU_DIV_EN is defined.
module mult_div_unit #(
  parameter int WIDTH = mdu_pkg::WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   src_a_i,
  input  logic [WIDTH-1:0]   src_b_i,
  input  logic               hi_write_i,
  input  logic               lo_write_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               div_by_zero_o,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o,
  output mdu_pkg::state_e    state_o
);
  import mdu_pkg::*;

  localparam int CW = $clog2(ITER_COUNT);

  state_e           state_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, mag_b_q;
  logic [WIDTH-1:0] work_hi_q, work_lo_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [CW-1:0]    cnt_q;
  logic             done_q, dbz_q;
  logic             signed_op;
  logic [WIDTH:0]   mul_sum;

  // Signed ops are the even encodings (MULT, DIV).
  assign signed_op = ~op_q[0];
  assign mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, mag_b_q} : {(WIDTH+1){1'b0}});

`ifdef MDU_DIV_EN
  logic [WIDTH-1:0] div_rem, div_quo;

  mdu_div_step #(.W(WIDTH)) u_div_step (
    .rem_i    (work_hi_q),
    .quo_i    (work_lo_q),
    .divisor_i(mag_b_q),
    .rem_o    (div_rem),
    .quo_o    (div_quo)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_MULT;
      a_q       <= '0;
      b_q       <= '0;
      mag_b_q   <= '0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            op_q      <= op_i;
            a_q       <= src_a_i;
            b_q       <= src_b_i;
            mag_b_q   <= abs_val(src_b_i, ~op_i[0]);
            work_hi_q <= '0;
            work_lo_q <= abs_val(src_a_i, ~op_i[0]);
            cnt_q     <= '0;
            if (!op_i[1]) begin
              state_q <= S_MUL;
            end else begin
`ifdef MDU_DIV_EN
              state_q <= S_DIV;
`else
              state_q <= S_DONE;
`endif
            end
          end else begin
            if (hi_write_i) hi_q <= src_a_i;
            if (lo_write_i) lo_q <= src_a_i;
          end
        end
        S_MUL: begin
          {work_hi_q, work_lo_q} <= {mul_sum, work_lo_q[WIDTH-1:1]};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(ITER_COUNT - 1)) state_q <= S_FIXUP;
        end
        S_DIV: begin
`ifdef MDU_DIV_EN
          work_hi_q <= div_rem;
          work_lo_q <= div_quo;
`endif
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(ITER_COUNT - 1)) state_q <= S_FIXUP;
        end
        S_FIXUP: begin
          if (!op_q[1]) begin
            if (signed_op && (a_q[WIDTH-1] ^ b_q[WIDTH-1]))
              {work_hi_q, work_lo_q} <= -{work_hi_q, work_lo_q};
          end else if (b_q == '0) begin
            work_hi_q <= a_q;
            work_lo_q <= '1;
          end else if (signed_op) begin
            // Quotient truncates toward zero; remainder follows the dividend.
            if (a_q[WIDTH-1] ^ b_q[WIDTH-1]) work_lo_q <= -work_lo_q;
            if (a_q[WIDTH-1])                work_hi_q <= -work_hi_q;
          end
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
`ifdef MDU_DIV_EN
          hi_q  <= work_hi_q;
          lo_q  <= work_lo_q;
          dbz_q <= op_q[1] && (b_q == '0);
`else
          if (!op_q[1]) begin
            hi_q <= work_hi_q;
            lo_q <= work_lo_q;
          end
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = done_q;
  assign div_by_zero_o = dbz_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table plus hand sequences for
// MTHI/MTLO, ignored restarts, overflow and mid-operation reset.
module tb_mult_div_unit;
  import mdu_pkg::*;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] src_a_i = '0;
  logic [31:0] src_b_i = '0;
  logic        hi_write_i = 1'b0;
  logic        lo_write_i = 1'b0;
  logic        busy_o, done_o, div_by_zero_o;
  logic [31:0] hi_o, lo_o;
  state_e      state_o;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .op_i         (op_i),
    .src_a_i      (src_a_i),
    .src_b_i      (src_b_i),
    .hi_write_i   (hi_write_i),
    .lo_write_i   (lo_write_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .div_by_zero_o(div_by_zero_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o),
    .state_o      (state_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one operation; disturb drives HI/LO writes throughout and a second Start at edge 10.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo, input logic dbz,
                        input bit disturb, input string tag);
    logic [31:0] e_hi, e_lo, old_hi, old_lo;
    logic        e_dbz, held, seen, extra;
    logic [63:0] exp_res;
    int          lat, exp_lat;
    if (op[1] && !DIV_EN) begin
      e_hi = m_hi; e_lo = m_lo; e_dbz = 1'b0; exp_lat = 1;
    end else begin
      e_hi = hi; e_lo = lo; e_dbz = dbz; exp_lat = 34;
    end
    exp_q.push_back({e_hi, e_lo});
    old_hi = m_hi; old_lo = m_lo;
    held = 1'b1; seen = 1'b0; extra = 1'b0; lat = 0;

    @(negedge clk);
    start_i = 1'b1; op_i = op; src_a_i = a; src_b_i = b;
    if (disturb) begin hi_write_i = 1'b1; lo_write_i = 1'b1; end
    @(posedge clk); #1;
    check({tag, "_busy"}, 64'(busy_o), 64'd1);
    start_i = 1'b0; op_i = ~op; src_a_i = 32'h5A5A_A5A5; src_b_i = 32'h0000_0003;

    for (int e = 1; e <= 100; e++) begin
      @(posedge clk); #1;
      if (done_o) begin
        seen = 1'b1; lat = e;
        break;
      end
      if (hi_o !== old_hi || lo_o !== old_lo) held = 1'b0;
      if (disturb) start_i = (e == 9);
    end
    start_i = 1'b0; hi_write_i = 1'b0; lo_write_i = 1'b0;

    exp_res = exp_q.pop_front();
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_hold"}, 64'(held), 64'd1);
    check({tag, "_hilo"}, {hi_o, lo_o}, exp_res);
    check({tag, "_dbz"}, 64'(div_by_zero_o), 64'(e_dbz));
    check({tag, "_idle_at_done"}, 64'(busy_o), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (done_o || busy_o) extra = 1'b1;
    end
    check({tag, "_single_done"}, 64'(extra), 64'd0);
    m_hi = e_hi; m_lo = e_lo;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1]  = '{OP_MULT,  32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[2]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[3]  = '{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0};
    vecs[4]  = '{OP_MULT,  32'h0000_0005, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFEC, 1'b0};
    vecs[5]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[6]  = '{OP_DIVU,  32'd100,       32'h0000_0000, 32'd100,       32'hFFFF_FFFF, 1'b1};
    vecs[7]  = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[8]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
    vecs[9]  = '{OP_DIV,   32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1};
    vecs[10] = '{OP_MULT,  32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0};

    // Reset state
    #12;
    check("reset_hilo", {hi_o, lo_o}, 64'd0);
    check("reset_busy", 64'(busy_o), 64'd0);
    check("reset_done", 64'({done_o, div_by_zero_o}), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 11; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dbz, 1'b0,
             $sformatf("vec%0d", i));

    // Signed overflow with an ignored restart and busy-time HI/LO writes
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1, "div_ovf");

    // MTHI / MTLO in idle, then writes during busy are dropped
    @(negedge clk); hi_write_i = 1'b1; src_a_i = 32'h0000_1234;
    @(posedge clk); #1;
    hi_write_i = 1'b0;
    check("mthi_value", 64'(hi_o), 64'h1234);
    check("mthi_no_done", 64'(done_o), 64'd0);
    m_hi = 32'h0000_1234;
    @(negedge clk); lo_write_i = 1'b1; src_a_i = 32'h0000_ABCD;
    @(posedge clk); #1;
    lo_write_i = 1'b0;
    check("mtlo_value", 64'(lo_o), 64'hABCD);
    m_lo = 32'h0000_ABCD;
    run_op(OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1'b1, "mul_after_mthi");

    // Reset in the middle of an operation
    run_op(OP_MULTU, 32'h0000_0100, 32'h0100_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, "pre_abort");
    @(negedge clk);
    start_i = 1'b1; op_i = OP_MULTU; src_a_i = 32'hFFFF_FFFF; src_b_i = 32'h0000_0002;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_hilo", {hi_o, lo_o}, 64'd0);
    check("abort_busy", 64'(busy_o), 64'd0);
    check("abort_done", 64'(done_o), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    m_hi = '0; m_lo = '0;
    run_op(OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1'b0, "mul_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand and HI/LO width; only 32 is supported.
REQ-002 Clock  input  1  Single clock; all state updates on its rising edge.
REQ-003 Reset  input  1  Asynchronous, active-low reset.
REQ-004 Start  input  1  Launch the operation selected by Op; sampled only when Busy=0.
REQ-005 Op  input  2  Operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SrcA  input  32  rs operand (register-file ReadData1); dividend or multiplicand; also the MTHI/MTLO data.
REQ-007 SrcB  input  32  rt operand (register-file ReadData2); divisor or multiplier.
REQ-008 HiWrite  input  1  MTHI: HI <= SrcA.
REQ-009 LoWrite  input  1  MTLO: LO <= SrcA.
REQ-010 Busy  output  1  Operation in progress.
REQ-011 Done  output  1  One-cycle pulse; HI/LO hold the result.
REQ-012 DivByZero  output  1  Pulses with Done when a DIV/DIVU had SrcB=0.
REQ-013 Hi  output  32  HI register (MFHI source).
REQ-014 Lo  output  32  LO register (MFLO source).

Function
REQ-015 The FSM SHALL have the states IDLE, MUL, DIV, FIXUP and DONE.
REQ-016 Transitions: IDLE->MUL or DIV on Start; MUL/DIV->FIXUP after 32 iterations; FIXUP->DONE; DONE->IDLE unconditionally.
REQ-017 SrcA, SrcB and Op SHALL be latched on the edge that accepts Start; later input changes have no effect.
REQ-018 MUL/MULTU: radix-2 shift-add over 32 cycles; {Hi,Lo} = the full 64-bit product.
REQ-019 Signed operations SHALL use magnitudes; FIXUP applies sign correction.
REQ-020 DIV/DIVU: restoring division over 32 cycles; Lo = quotient, Hi = remainder.
REQ-021 Signed DIV: quotient truncates toward zero; the remainder takes the dividend's sign.
REQ-022 Latency: Busy=1 from the edge accepting Start; Hi, Lo and Done update on the 34th edge after that edge; Busy=0 on the same edge Done rises.
REQ-023 Start while Busy=1 SHALL be ignored.
REQ-024 HiWrite/LoWrite while Busy=1 SHALL be ignored.
REQ-025 Start together with HiWrite/LoWrite in IDLE: Start wins; the writes are dropped.
REQ-026 HiWrite/LoWrite in IDLE SHALL update the register on the next edge; Done is not asserted.
REQ-027 Divide by zero: same latency; Hi = dividend, Lo = 32'hFFFFFFFF, DivByZero=1 with Done.
REQ-028 Signed overflow 32'h80000000 / 32'hFFFFFFFF: Lo = 32'h80000000, Hi = 0, no flag.
REQ-029 Hi and Lo SHALL NOT change during MUL, DIV or FIXUP; the old values stay visible until Done.

Reset
REQ-030 Reset=0 SHALL force IDLE, Hi=0, Lo=0, Busy=0, Done=0 and DivByZero=0 immediately.
REQ-031 Reset mid-operation SHALL abort with no result written; the first Start after release behaves normally.

Configuration
REQ-032 Macro MDU_DIV_EN defined: DIV/DIVU behave as specified above.
REQ-033 MDU_DIV_EN undefined: no divider logic; a DIV/DIVU Start pulses Done one edge later, with Hi/Lo unchanged and DivByZero=0.

Structure
REQ-034 Shared package mdu_pkg SHALL hold WIDTH, the Op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), the state enum and ITER_COUNT=32.
REQ-035 One sub-module, mdu_div_step, SHALL be combinational and perform one restoring-divide iteration; it is instantiated only under MDU_DIV_EN.

Verification
REQ-036 MULTU SrcA=32'hFFFFFFFF, SrcB=32'hFFFFFFFF -> Done at edge 34; Hi=32'hFFFFFFFE, Lo=32'h00000001.
REQ-037 MULT SrcA=-7, SrcB=3 -> Hi=32'hFFFFFFFF, Lo=32'hFFFFFFEB.
REQ-038 DIV SrcA=-7, SrcB=2 -> Lo=32'hFFFFFFFD, Hi=32'hFFFFFFFF; DIVU 100/0 -> Hi=100, Lo=32'hFFFFFFFF, DivByZero=1.
REQ-039 DIV 32'h80000000 / 32'hFFFFFFFF -> Lo=32'h80000000, Hi=0; a second Start at edge 10 is ignored, and Done pulses exactly once.
REQ-040 MTHI 32'h1234 in IDLE, then HiWrite during Busy -> Hi=32'h1234 until Done overwrites it.
REQ-041 Reset=0 at iteration 15 -> Hi=Lo=0 and Busy=0 at once; a new MULTU 3*5 gives Lo=15 after 34 edges.
